// File: rtl/czonotope_stream_out.sv
// Serialises a result CZonotope (c, G row-major, A row-major, b) from sync-read memories onto a valid/ready stream.
// Optional leading header word (tag 0, {nc,ng,n}) when CZ_STREAM_HEADER_EN is defined.
module czonotope_stream_out #(
  parameter int NMAX       = 3,
  parameter int NGMAX      = 15,
  parameter int NCMAX      = 12,
  parameter int DATA_WIDTH = 32,
  localparam int NW = $clog2(NMAX) + 1,
  localparam int GW = $clog2(NGMAX) + 1,
  localparam int CW = $clog2(NCMAX) + 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [NW-1:0]         n_i,
  input  logic [GW-1:0]         ng_i,
  input  logic [CW-1:0]         nc_i,
  output logic [NW-1:0]         c_addr,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  output logic [NW-1:0]         G_raddr,
  output logic [GW-1:0]         G_caddr,
  input  logic [DATA_WIDTH-1:0] G_rdata,
  output logic [CW-1:0]         A_raddr,
  output logic [GW-1:0]         A_caddr,
  input  logic [DATA_WIDTH-1:0] A_rdata,
  output logic [CW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [2:0]            m_tag,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, SEC_C, SEC_G, SEC_A, SEC_B, DRAIN} state_t;

  state_t                  state, first_sec, nxt_sec, after_c, after_g, after_a, ent_sec;
  logic [NW-1:0]           n_q, dn;
  logic [GW-1:0]           ng_q, dng;
  logic [CW-1:0]           nc_q, dnc;
  logic                    idle, has_c, has_g, has_a, has_b, bad;
  logic                    sec_end, issue, ent_en, pop, push;
  logic [2:0]              occ, sec_tag;
  logic                    rd_vld, rd_last, hdr_pend, hdr_last;
  logic [2:0]              rd_tag;
  logic [1:0]              cnt;
  logic [DATA_WIDTH-1:0]   rd_dat, hdr_word, push_dat, b1_dat;
  logic [2:0]              push_tag, b1_tag;
  logic                    push_last, b1_last;

  always_comb begin
    idle  = (state == IDLE);
    // section skipping is decided from live dims at start, latched dims afterwards
    dn    = idle ? n_i  : n_q;
    dng   = idle ? ng_i : ng_q;
    dnc   = idle ? nc_i : nc_q;
    has_c = (dn != '0);
    has_g = has_c && (dng != '0);
    has_b = (dnc != '0);
    has_a = has_b && (dng != '0);
    after_a   = has_b ? SEC_B : DRAIN;
    after_g   = has_a ? SEC_A : after_a;
    after_c   = has_g ? SEC_G : after_g;
    first_sec = has_c ? SEC_C : after_c;
    bad = (n_i > NW'(NMAX)) || (ng_i > GW'(NGMAX)) || (nc_i > CW'(NCMAX));

    sec_end = 1'b0;
    nxt_sec = DRAIN;
    sec_tag = 3'd0;
    case (state)
      SEC_C: begin
        sec_end = (c_addr == n_q - NW'(1));
        nxt_sec = after_c;
        sec_tag = 3'd1;
      end
      SEC_G: begin
        sec_end = (G_raddr == n_q - NW'(1)) && (G_caddr == ng_q - GW'(1));
        nxt_sec = after_g;
        sec_tag = 3'd2;
      end
      SEC_A: begin
        sec_end = (A_raddr == nc_q - CW'(1)) && (A_caddr == ng_q - GW'(1));
        nxt_sec = after_a;
        sec_tag = 3'd3;
      end
      SEC_B: begin
        sec_end = (b_addr == nc_q - CW'(1));
        nxt_sec = DRAIN;
        sec_tag = 3'd4;
      end
      default: ;
    endcase

    pop = m_valid & m_ready;
    // slots claimed after this edge; a pop this cycle frees one, so full rate needs no bubble
    occ   = 3'(cnt) + 3'(rd_vld) + 3'(hdr_pend) - 3'(pop);
    issue = (state inside {SEC_C, SEC_G, SEC_A, SEC_B}) && (occ < 3'd2);

    ent_en  = (idle && start_i && !bad) || (issue && sec_end);
    ent_sec = idle ? first_sec : nxt_sec;

    case (rd_tag)
      3'd1:    rd_dat = c_rdata;
      3'd2:    rd_dat = G_rdata;
      3'd3:    rd_dat = A_rdata;
      default: rd_dat = b_rdata;
    endcase

    hdr_word = '0;
    hdr_word[NW-1:0]  = n_q;
    hdr_word[8 +: GW] = ng_q;
    hdr_word[16 +: CW] = nc_q;

    push      = rd_vld | hdr_pend;
    push_dat  = hdr_pend ? hdr_word : rd_dat;
    push_tag  = hdr_pend ? 3'd0 : rd_tag;
    push_last = hdr_pend ? hdr_last : rd_last;
  end

  assign m_valid = (cnt != 2'd0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      n_q      <= '0;
      ng_q     <= '0;
      nc_q     <= '0;
      c_addr   <= '0;
      G_raddr  <= '0;
      G_caddr  <= '0;
      A_raddr  <= '0;
      A_caddr  <= '0;
      b_addr   <= '0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      rd_tag   <= '0;
      hdr_pend <= 1'b0;
      hdr_last <= 1'b0;
      cnt      <= '0;
      m_data   <= '0;
      m_tag    <= '0;
      m_last   <= 1'b0;
      b1_dat   <= '0;
      b1_tag   <= '0;
      b1_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      hdr_pend <= 1'b0;
      rd_vld   <= issue;
      if (issue) begin
        rd_tag  <= sec_tag;
        rd_last <= sec_end && (nxt_sec == DRAIN);
      end

      // two-entry output buffer: head entry drives the stream ports directly
      if (push && !pop) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd0) {m_data, m_tag, m_last} <= {push_dat, push_tag, push_last};
        else             {b1_dat, b1_tag, b1_last} <= {push_dat, push_tag, push_last};
      end else if (!push && pop) begin
        cnt <= cnt - 2'd1;
        {m_data, m_tag, m_last} <= {b1_dat, b1_tag, b1_last};
      end else if (push && pop) begin
        if (cnt == 2'd1) begin
          {m_data, m_tag, m_last} <= {push_dat, push_tag, push_last};
        end else begin
          {m_data, m_tag, m_last} <= {b1_dat, b1_tag, b1_last};
          {b1_dat, b1_tag, b1_last} <= {push_dat, push_tag, push_last};
        end
      end

      case (state)
        IDLE: if (start_i) begin
          n_q  <= n_i;
          ng_q <= ng_i;
          nc_q <= nc_i;
          busy <= 1'b1;
          err  <= bad;
          if (bad) begin
            state <= DRAIN;
          end else begin
            state    <= first_sec;
            hdr_last <= (first_sec == DRAIN);
`ifdef CZ_STREAM_HEADER_EN
            hdr_pend <= 1'b1;
`endif
          end
        end
        SEC_C, SEC_G, SEC_A, SEC_B: if (issue) begin
          if (sec_end) begin
            state <= nxt_sec;
          end else begin
            case (state)
              SEC_C: c_addr <= c_addr + NW'(1);
              SEC_G: if (G_caddr == ng_q - GW'(1)) begin
                G_caddr <= '0;
                G_raddr <= G_raddr + NW'(1);
              end else G_caddr <= G_caddr + GW'(1);
              SEC_A: if (A_caddr == ng_q - GW'(1)) begin
                A_caddr <= '0;
                A_raddr <= A_raddr + CW'(1);
              end else A_caddr <= A_caddr + GW'(1);
              default: b_addr <= b_addr + CW'(1);
            endcase
          end
        end
        DRAIN: if ((cnt == 2'd0) && !rd_vld && !hdr_pend) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // only the section being entered rewinds its addresses; others keep their last value
      if (ent_en) begin
        case (ent_sec)
          SEC_C: c_addr <= '0;
          SEC_G: begin G_raddr <= '0; G_caddr <= '0; end
          SEC_A: begin A_raddr <= '0; A_caddr <= '0; end
          SEC_B: b_addr <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule
